icache_resp: RTL and testbench

- Instruction-memory responder for the 2-wide fetch stage: serves proc2Imem_addr with one 64-bit line (two 32-bit instructions) plus per-word valid.
- Direct-mapped, 8-byte lines, valid bits per line.
- On a miss it runs a tagged LOAD transaction on the main-memory bus and fills the line.
- Sits between the fetch stage and the memory arbiter.

---
 rtl/icache_resp.sv | 147 ++++++++++++++
 tb/tb_icache_resp.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_resp.sv
// icache_resp: direct-mapped instruction cache responder for the 2-wide fetch stage.
// Serves one 64-bit line per fetch PC combinationally; misses run a tagged LOAD
// on the main-memory bus (IDLE -> REQ -> WAIT) and fill the line on tag match.
// Optional statistics counters are built only when ICACHE_STATS_EN is defined.
module icache_resp #(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned MEM_TAG_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [63:0]          proc2Imem_addr,
  output logic [63:0]          Imem2proc_data,
  output logic [1:0]           Imem_valid,
  output logic [1:0]           proc2mem_command,
  output logic [63:0]          proc2mem_addr,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [63:0]          mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 61 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic [1:0] {CMD_NONE = 2'd0, CMD_LOAD = 2'd1} cmd_t;

  state_t                 state_q, state_d;
  cmd_t                   cmd_q, cmd_d;
  logic [63:0]            miss_addr_q, miss_addr_d;
  logic [MEM_TAG_W-1:0]   cur_tag_q, cur_tag_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [63:0]            data_q [NUM_LINES];
  logic [TAG_W-1:0]       tags_q [NUM_LINES];

  logic [IDX_W-1:0]       rd_idx, fill_idx;
  logic [TAG_W-1:0]       rd_tag, fill_tag;
  logic                   hit, fill_en;
  logic [1:0]             unused_addr_bits;

  assign unused_addr_bits = proc2Imem_addr[1:0];
  assign rd_idx   = proc2Imem_addr[3 +: IDX_W];
  assign rd_tag   = proc2Imem_addr[63 -: TAG_W];
  assign fill_idx = miss_addr_q[3 +: IDX_W];
  assign fill_tag = miss_addr_q[63 -: TAG_W];

  // Zero-latency lookup; data is driven whether or not the lookup hits.
  always_comb begin
    hit            = valid_q[rd_idx] && (tags_q[rd_idx] == rd_tag);
    Imem2proc_data = data_q[rd_idx];
    Imem_valid     = 2'b00;
    if (hit) Imem_valid = proc2Imem_addr[2] ? 2'b10 : 2'b11;
  end

  // Miss sequencing; a redirect never cancels the fill, it only waits for IDLE.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    cur_tag_d   = cur_tag_q;
    valid_d     = valid_q;
    fill_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!hit) begin
          miss_addr_d = {proc2Imem_addr[63:3], 3'b000};
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem2proc_response != '0) begin
          cur_tag_d = mem2proc_response;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if ((cur_tag_q != '0) && (mem2proc_tag == cur_tag_q)) begin
          fill_en           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cmd_d = (state_d == S_REQ) ? CMD_LOAD : CMD_NONE;
  end

  // FSM state, latched miss/tag and per-line valid bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= CMD_NONE;
      miss_addr_q <= '0;
      cur_tag_q   <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      miss_addr_q <= miss_addr_d;
      cur_tag_q   <= cur_tag_d;
      valid_q     <= valid_d;
    end
  end

  // Line data and tag storage; gated by valid bits so no reset is needed.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      data_q[fill_idx] <= mem2proc_data;
      tags_q[fill_idx] <= fill_tag;
    end
  end

  assign proc2mem_command = cmd_q;
  assign proc2mem_addr    = miss_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  // Hits counted only while idle; each IDLE->REQ transition is one miss.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == S_IDLE) begin
      if (hit) hit_count_d  = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
  end

  // Statistics registers, wrapping at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_resp.sv
// tb_icache_resp: directed vector table plus randomized run against a
// transaction-level cache model for icache_resp.
module tb_icache_resp;

`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] proc2Imem_addr;
  logic [63:0] Imem2proc_data;
  logic [1:0]  Imem_valid;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_resp #(.NUM_LINES(32), .MEM_TAG_W(4)) dut (
    .clock(clock), .reset(reset),
    .proc2Imem_addr(proc2Imem_addr), .Imem2proc_data(Imem2proc_data),
    .Imem_valid(Imem_valid), .proc2mem_command(proc2mem_command),
    .proc2mem_addr(proc2mem_addr), .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] mdata;
    logic [1:0]  ev;
    logic [63:0] ed;
    logic [1:0]  ec;
    logic [63:0] ea;
  } vec_t;

  function automatic vec_t mk(input logic [63:0] addr, input logic [3:0] resp,
                              input logic [3:0] tag, input logic [63:0] mdata,
                              input logic [1:0] ev, input logic [63:0] ed,
                              input logic [1:0] ec, input logic [63:0] ea);
    vec_t v;
    v.addr = addr; v.resp = resp; v.tag = tag; v.mdata = mdata;
    v.ev = ev; v.ed = ed; v.ec = ec; v.ea = ea;
    return v;
  endfunction

  localparam logic [63:0] D0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D1 = 64'h0123_4567_89ab_cdef;
  localparam logic [63:0] D2 = 64'hdead_beef_cafe_f00d;
  localparam logic [63:0] D3 = 64'haaaa_bbbb_cccc_dddd;
  localparam logic [63:0] D4 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D5 = 64'h9999_0000_1212_3434;

  // Reference model: line contents by index, plus one outstanding transaction.
  bit          m_valid [32];
  logic [60:0] m_line  [32];
  logic [63:0] m_data  [32];
  bit          busy, acc;
  logic [60:0] req_line;
  logic [3:0]  req_tag;
  logic [31:0] m_hits, m_miss;

  vec_t vt[$];

  initial begin
    reset = 1'b1;
    proc2Imem_addr = '0; mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    #1;
    chk("rst_valid", Imem_valid, 2'b00);
    chk("rst_cmd", proc2mem_command, 2'd0);
    chk("rst_paddr", proc2mem_addr, 64'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    @(posedge clock); @(negedge clock); @(posedge clock); @(negedge clock);
    reset = 1'b0;

    //              addr       resp  tag   mdata ev     ed  ec    ea
    vt.push_back(mk(64'h000, 4'd0, 4'd0, '0, 2'b00, '0, 2'd0, '0));
    vt.push_back(mk(64'h000, 4'd1, 4'd0, '0, 2'b00, '0, 2'd1, 64'h000));
    vt.push_back(mk(64'h000, 4'd0, 4'd1, D0, 2'b00, '0, 2'd0, '0));
    vt.push_back(mk(64'h000, 4'd0, 4'd0, '0, 2'b11, D0, 2'd0, '0));
    vt.push_back(mk(64'h100, 4'd0, 4'd0, '0, 2'b00, '0, 2'd0, '0));
    vt.push_back(mk(64'h100, 4'd3, 4'd0, '0, 2'b00, '0, 2'd1, 64'h100));
    vt.push_back(mk(64'h100, 4'd0, 4'd2, D5, 2'b00, '0, 2'd0, '0));
    vt.push_back(mk(64'h100, 4'd0, 4'd3, D1, 2'b00, '0, 2'd0, '0));
    vt.push_back(mk(64'h100, 4'd0, 4'd0, '0, 2'b11, D1, 2'd0, '0));
    vt.push_back(mk(64'h104, 4'd0, 4'd0, '0, 2'b10, D1, 2'd0, '0));
    vt.push_back(mk(64'h008, 4'd0, 4'd0, '0, 2'b00, '0, 2'd0, '0));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(64'h008, 4'd0, 4'd0, '0, 2'b00, '0, 2'd1, 64'h008));
    vt.push_back(mk(64'h008, 4'd5, 4'd0, '0, 2'b00, '0, 2'd1, 64'h008));
    vt.push_back(mk(64'h008, 4'd0, 4'd0, '0, 2'b00, '0, 2'd0, '0));
    vt.push_back(mk(64'h008, 4'd0, 4'd5, D2, 2'b00, '0, 2'd0, '0));
    vt.push_back(mk(64'h008, 4'd0, 4'd0, '0, 2'b11, D2, 2'd0, '0));
    vt.push_back(mk(64'h200, 4'd0, 4'd0, '0, 2'b00, '0, 2'd0, '0));
    vt.push_back(mk(64'h200, 4'd6, 4'd0, '0, 2'b00, '0, 2'd1, 64'h200));
    vt.push_back(mk(64'h100, 4'd0, 4'd0, '0, 2'b11, D1, 2'd0, '0));
    vt.push_back(mk(64'h100, 4'd0, 4'd6, D3, 2'b11, D1, 2'd0, '0));
    vt.push_back(mk(64'h100, 4'd0, 4'd0, '0, 2'b00, '0, 2'd0, '0));
    vt.push_back(mk(64'h200, 4'd7, 4'd0, '0, 2'b11, D3, 2'd1, 64'h100));
    vt.push_back(mk(64'h200, 4'd0, 4'd7, D4, 2'b11, D3, 2'd0, '0));
    vt.push_back(mk(64'h100, 4'd0, 4'd0, '0, 2'b11, D4, 2'd0, '0));

    for (int i = 0; i < vt.size(); i++) begin
      proc2Imem_addr = vt[i].addr; mem2proc_response = vt[i].resp;
      mem2proc_tag = vt[i].tag; mem2proc_data = vt[i].mdata;
      #1;
      chk($sformatf("vec%0d_valid", i), Imem_valid, vt[i].ev);
      chk($sformatf("vec%0d_cmd", i), proc2mem_command, vt[i].ec);
      if (vt[i].ev != 2'b00) chk($sformatf("vec%0d_data", i), Imem2proc_data, vt[i].ed);
      if (vt[i].ec == 2'd1)  chk($sformatf("vec%0d_paddr", i), proc2mem_addr, vt[i].ea);
      tick();
    end
    chk("tbl_hits", hit_count, STATS ? 32'd5 : 32'd0);
    chk("tbl_miss", miss_count, STATS ? 32'd5 : 32'd0);

    // Reset abandoning a miss in WAIT; the stale tag must not fill afterwards.
    proc2Imem_addr = 64'h018; mem2proc_response = 4'd0; mem2proc_tag = 4'd0;
    tick();
    mem2proc_response = 4'd4;
    tick();
    mem2proc_response = 4'd0; proc2Imem_addr = 64'h100;
    #1 chk("hum_valid", Imem_valid, 2'b11);
    #1 reset = 1'b1;
    #1;
    chk("arst_valid", Imem_valid, 2'b00);
    chk("arst_cmd", proc2mem_command, 2'd0);
    chk("arst_paddr", proc2mem_addr, 64'd0);
    chk("arst_hits", hit_count, 32'd0);
    tick();
    reset = 1'b0;
    proc2Imem_addr = 64'h018; mem2proc_tag = 4'd4;
    tick();
    #1 chk("rr_cmd", proc2mem_command, 2'd1);
    chk("rr_paddr", proc2mem_addr, 64'h018);
    mem2proc_response = 4'd9;
    tick();
    mem2proc_response = 4'd0; mem2proc_tag = 4'd4;
    #1 chk("stale_cmd", proc2mem_command, 2'd0);
    tick();
    mem2proc_tag = 4'd0;
    #1 chk("stale_valid", Imem_valid, 2'b00);
    mem2proc_tag = 4'd9; mem2proc_data = D5;
    tick();
    mem2proc_tag = 4'd0;
    #1 chk("rr_fill_valid", Imem_valid, 2'b11);
    chk("rr_fill_data", Imem2proc_data, D5);

    // Randomized run against the model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    busy = 1'b0; acc = 1'b0; req_line = '0; req_tag = '0; m_hits = '0; m_miss = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [63:0] pc, hi;
      logic [4:0]  idx;
      logic [60:0] line;
      bit          h;
      logic [1:0]  ev;
      if (cyc == 0 || $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0: hi = 64'h0;
          1: hi = 64'h100;
          default: hi = 64'h8000_0000_0000_0000;
        endcase
        pc = hi | (64'($urandom_range(0, 3)) << 3) | 64'($urandom_range(0, 7));
        proc2Imem_addr = pc;
      end
      pc = proc2Imem_addr;
      mem2proc_response = (busy && !acc && $urandom_range(0, 2) == 0) ? 4'd0
                                                                      : 4'($urandom_range(0, 15));
      mem2proc_tag  = (busy && acc && $urandom_range(0, 2) == 0) ? req_tag
                                                                  : 4'($urandom_range(0, 15));
      mem2proc_data = {$urandom, $urandom};
      line = pc[63:3];
      idx  = line[4:0];
      h    = m_valid[idx] && (m_line[idx] == line);
      ev   = h ? (pc[2] ? 2'b10 : 2'b11) : 2'b00;
      #1;
      chk("rnd_valid", Imem_valid, ev);
      if (h) chk("rnd_data", Imem2proc_data, m_data[idx]);
      chk("rnd_cmd", proc2mem_command, (busy && !acc) ? 2'd1 : 2'd0);
      if (busy && !acc) chk("rnd_paddr", proc2mem_addr, {req_line, 3'b000});
      chk("rnd_hits", hit_count, STATS ? m_hits : 32'd0);
      chk("rnd_miss", miss_count, STATS ? m_miss : 32'd0);
      @(posedge clock);
      if (!busy) begin
        if (h) m_hits++;
        else begin busy = 1'b1; acc = 1'b0; req_line = line; m_miss++; end
      end else if (!acc) begin
        if (mem2proc_response != 4'd0) begin acc = 1'b1; req_tag = mem2proc_response; end
      end else if (mem2proc_tag == req_tag) begin
        m_valid[req_line[4:0]] = 1'b1;
        m_line[req_line[4:0]]  = req_line;
        m_data[req_line[4:0]]  = mem2proc_data;
        busy = 1'b0;
      end
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
